fp_sgnj_arbiter: RTL and testbench
==================================

// Module: fp_sgnj_arbiter
// PURPOSE
//  - Shares one fp_sgnj sign-injection datapath among NUM_REQ issue ports (FSGNJ/FSGNJN/FSGNJX, S and D).
//  - Round-robin arbitration, one registered output stage, valid/ready on both sides.
//  - Sits between the FPU issue stage(s) and the FP writeback mux.
// PARAMETERS
//  NUM_REQ  2   number of requesters (>=2)
//  TAG_W    4   width of per-request tag echoed with the result
//  CNT_W    16  width of accepted-operation counter
// PORTS
//  clk              in   1                 clock
//  rst_n            in   1                 asynchronous active-low reset
//  req_valid_i      in   NUM_REQ           request valid per port
//  req_ready_o      out  NUM_REQ           request accepted this cycle (one-hot or zero)
//  req_data1_i      in   NUM_REQ x 64      operand 1 (magnitude source)
//  req_data2_i      in   NUM_REQ x 64      operand 2 (sign source)
//  req_fmt_i        in   NUM_REQ x 2       0=single, 1=double
//  req_rm_i         in   NUM_REQ x 3       0=J, 1=JN, 2=JX
//  req_tag_i        in   NUM_REQ x TAG_W   opaque tag
//  resp_valid_o     out  1                 result register valid
//  resp_ready_i     in   1                 consumer accepts result
//  resp_result_o    out  64                result (upper bits zero for single)
//  resp_tag_o       out  TAG_W             tag of the granted request
//  resp_src_o       out  SRC_W             granted port index, SRC_W = max(1,$clog2(NUM_REQ))
//  resp_illegal_o   out  1                 fmt>1 or rm>2; result forced to 0
//  op_cnt_o         out  CNT_W             count of accepted requests, wraps
// BEHAVIOUR
//  - Reset (async, rst_n=0): resp_valid_o=0, resp_result_o=0, resp_tag_o=0, resp_src_o=0,
//    resp_illegal_o=0, op_cnt_o=0, RR pointer=0. An in-flight result is dropped, not replayed.
//  - can_accept = !resp_valid_o | resp_ready_i (combinational).
//  - Grant: if can_accept, lowest-index valid port at or after the pointer, wrapping modulo NUM_REQ.
//    req_ready_o has exactly the granted bit set. If !can_accept, req_ready_o = 0.
//  - Granted operands drive fp_sgnj combinationally; result, tag, src and illegal are registered
//    on the same edge. Latency 1: accepted in cycle k -> resp_valid_o=1 in cycle k+1.
//  - Pointer <= grant_idx+1 (wraps NUM_REQ-1 -> 0) on accept only; unchanged when nothing is granted.
//  - Hold: resp_valid_o & !resp_ready_i -> all resp_* stable, no grant.
//  - Pop and push in the same cycle: new result replaces old; throughput 1 op/cycle.
//  - Pop with no push: resp_valid_o <= 0; data registers keep their values.
//  - Illegal encodings are accepted and counted: resp_illegal_o=1, resp_result_o=0.
//  - op_cnt_o increments by 1 per accepted request; wraps 2^CNT_W-1 -> 0.
//  - req_valid_i may drop without a handshake. Never combinational from resp_ready_i to resp_*.
// STRUCTURE
//  - fp_types package: fp_sgnj_in_type / fp_sgnj_out_type (existing); add constants
//    FP_FMT_S=0, FP_FMT_D=1, SGNJ_RM_J=0, SGNJ_RM_JN=1, SGNJ_RM_JX=2.
//  - One sub-module: a single fp_sgnj instance fed from the grant mux.
//  - RR pick: inline function. No second sub-module.
// TESTING
//  1. Port0 only, fmt=0 rm=0 d1=0x3F800000 d2=0x80000000 tag=5
//     -> next cycle result 0xBF800000, tag 5, src 0, cnt 1.
//  2. Ports 0,1 valid every cycle, resp_ready=1 -> grants 0,1,0,1; one result/cycle; cnt +1/cycle.
//  3. resp_ready=0 for 3 cycles while both ports valid -> req_ready_o=0, resp_* frozen;
//     release -> next grant honours the pointer.
//  4. fmt=1 rm=2 d1=0xC000000000000000 d2=0x8000000000000000 -> 0x4000000000000000;
//     fmt=1 rm=1 d1=0x3FF0000000000000 d2=0 -> 0xBFF0000000000000.
//  5. rm=3, or fmt=2 -> illegal=1, result 0, counted; CNT_W=4 with 17 ops -> op_cnt_o=1.
//  6. Assert rst_n low while resp_valid_o=1 and resp_ready_i=0 -> outputs zero immediately;
//     first grant after release goes to port 0.

Source files
------------

// File: rtl/fp_types.sv
// Shared FP sign-injection types and encodings.
package fp_types;

  localparam logic [1:0] FP_FMT_S   = 2'd0;
  localparam logic [1:0] FP_FMT_D   = 2'd1;
  localparam logic [2:0] SGNJ_RM_J  = 3'd0;
  localparam logic [2:0] SGNJ_RM_JN = 3'd1;
  localparam logic [2:0] SGNJ_RM_JX = 3'd2;

  typedef struct packed {
    logic [63:0] data1;
    logic [63:0] data2;
    logic [1:0]  fmt;
    logic [2:0]  rm;
  } fp_sgnj_in_type;

  typedef struct packed {
    logic [63:0] result;
    logic        illegal;
  } fp_sgnj_out_type;

endpackage

// File: rtl/fp_sgnj.sv
// Combinational sign injection: magnitude from data1, sign derived from data2 per rm.
module fp_sgnj
  import fp_types::*;
(
  input  fp_sgnj_in_type  sgnj_i,
  output fp_sgnj_out_type sgnj_o
);

  logic s1, s2, sgn;

  always_comb begin
    sgnj_o  = '0;
    s1      = (sgnj_i.fmt == FP_FMT_D) ? sgnj_i.data1[63] : sgnj_i.data1[31];
    s2      = (sgnj_i.fmt == FP_FMT_D) ? sgnj_i.data2[63] : sgnj_i.data2[31];
    case (sgnj_i.rm)
      SGNJ_RM_JN: sgn = ~s2;
      SGNJ_RM_JX: sgn = s1 ^ s2;
      default:    sgn = s2;
    endcase
    sgnj_o.illegal = (sgnj_i.fmt > FP_FMT_D) || (sgnj_i.rm > SGNJ_RM_JX);
    if (!sgnj_o.illegal) begin
      if (sgnj_i.fmt == FP_FMT_D) sgnj_o.result = {sgn, sgnj_i.data1[62:0]};
      else                        sgnj_o.result = {32'b0, sgn, sgnj_i.data1[30:0]};
    end
  end

endmodule

// File: rtl/fp_sgnj_arbiter.sv
// Round-robin share of one fp_sgnj datapath across NUM_REQ ports, single registered result stage.
module fp_sgnj_arbiter
  import fp_types::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int TAG_W   = 4,
  parameter  int CNT_W   = 16,
  localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ-1:0][63:0]         req_data1_i,
  input  logic [NUM_REQ-1:0][63:0]         req_data2_i,
  input  logic [NUM_REQ-1:0][1:0]          req_fmt_i,
  input  logic [NUM_REQ-1:0][2:0]          req_rm_i,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]    req_tag_i,
  output logic                             resp_valid_o,
  input  logic                             resp_ready_i,
  output logic [63:0]                      resp_result_o,
  output logic [TAG_W-1:0]                 resp_tag_o,
  output logic [SRC_W-1:0]                 resp_src_o,
  output logic                             resp_illegal_o,
  output logic [CNT_W-1:0]                 op_cnt_o
);

  // Returns {found, idx}: first valid port at or after p, wrapping.
  function automatic logic [SRC_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [SRC_W-1:0]   p);
    logic             found;
    logic [SRC_W-1:0] idx;
    logic [SRC_W-1:0] ki;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ki = SRC_W'((int'(p) + i) % NUM_REQ);
      if (!found && v[ki]) begin
        found = 1'b1;
        idx   = ki;
      end
    end
    return {found, idx};
  endfunction

  logic             vld_q, vld_d;
  logic [63:0]      res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;

  logic             can_accept, grant;
  logic [SRC_W-1:0] gidx;
  logic [SRC_W:0]   pick;
  fp_sgnj_in_type   sgnj_in;
  fp_sgnj_out_type  sgnj_out;

  always_comb begin
    can_accept  = !vld_q || resp_ready_i;
    pick        = rr_pick(req_valid_i, ptr_q);
    grant       = can_accept && pick[SRC_W];
    gidx        = pick[SRC_W-1:0];
    req_ready_o = '0;
    if (grant) req_ready_o[gidx] = 1'b1;
    sgnj_in.data1 = req_data1_i[gidx];
    sgnj_in.data2 = req_data2_i[gidx];
    sgnj_in.fmt   = req_fmt_i[gidx];
    sgnj_in.rm    = req_rm_i[gidx];
  end

  fp_sgnj u_sgnj (
    .sgnj_i (sgnj_in),
    .sgnj_o (sgnj_out)
  );

  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    tag_d = tag_q;
    src_d = src_q;
    ill_d = ill_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    if (grant) begin
      vld_d = 1'b1;
      res_d = sgnj_out.result;
      tag_d = req_tag_i[gidx];
      src_d = gidx;
      ill_d = sgnj_out.illegal;
      cnt_d = cnt_q + 1'b1;
      ptr_d = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
    end else if (resp_ready_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      res_q <= '0;
      tag_q <= '0;
      src_q <= '0;
      ill_q <= 1'b0;
      cnt_q <= '0;
      ptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      tag_q <= tag_d;
      src_q <= src_d;
      ill_q <= ill_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
    end
  end

  assign resp_valid_o   = vld_q;
  assign resp_result_o  = res_q;
  assign resp_tag_o     = tag_q;
  assign resp_src_o     = src_q;
  assign resp_illegal_o = ill_q;
  assign op_cnt_o       = cnt_q;

endmodule

// File: tb/tb_fp_sgnj_arbiter.sv
// Directed bench for fp_sgnj_arbiter; a CNT_W=4 twin shares the stimulus to observe counter wrap.
module tb_fp_sgnj_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready, req_ready2;
  logic [1:0][63:0] d1, d2;
  logic [1:0][1:0]  fmt;
  logic [1:0][2:0]  rm;
  logic [1:0][3:0]  tag;
  logic             resp_ready;
  logic             rvld, rvld2;
  logic [63:0]      rres, rres2;
  logic [3:0]       rtag, rtag2;
  logic             rsrc, rsrc2;
  logic             rill, rill2;
  logic [15:0]      cnt;
  logic [3:0]       cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_sgnj_arbiter #(.NUM_REQ(2), .TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_data1_i(d1), .req_data2_i(d2), .req_fmt_i(fmt), .req_rm_i(rm), .req_tag_i(tag),
    .resp_valid_o(rvld), .resp_ready_i(resp_ready), .resp_result_o(rres), .resp_tag_o(rtag),
    .resp_src_o(rsrc), .resp_illegal_o(rill), .op_cnt_o(cnt)
  );

  fp_sgnj_arbiter #(.NUM_REQ(2), .TAG_W(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready2),
    .req_data1_i(d1), .req_data2_i(d2), .req_fmt_i(fmt), .req_rm_i(rm), .req_tag_i(tag),
    .resp_valid_o(rvld2), .resp_ready_i(resp_ready), .resp_result_o(rres2), .resp_tag_o(rtag2),
    .resp_src_o(rsrc2), .resp_illegal_o(rill2), .op_cnt_o(cnt2)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] f, input logic [2:0] r, input logic [3:0] t);
    d1[p] = a; d2[p] = b; fmt[p] = f; rm[p] = r; tag[p] = t;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(rvld), 64'd0);
    chk("rst_result", rres, 64'd0);
    chk("rst_tag", 64'(rtag), 64'd0);
    chk("rst_src", 64'(rsrc), 64'd0);
    chk("rst_ill", 64'(rill), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    req_valid  = '0;
    resp_ready = 1'b1;
    d1 = '0; d2 = '0; fmt = '0; rm = '0; tag = '0;
    #2;
    do_reset();

    // 1: single-precision FSGNJ on port 0
    tick();
    set_req(0, 64'h3F800000, 64'h80000000, 2'd0, 3'd0, 4'd5);
    req_valid = 2'b01;
    #1 chk("t1_ready", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b00;
    chk("t1_valid", 64'(rvld), 64'd1);
    chk("t1_result", rres, 64'hBF800000);
    chk("t1_tag", 64'(rtag), 64'd5);
    chk("t1_src", 64'(rsrc), 64'd0);
    chk("t1_cnt", 64'(cnt), 64'd1);

    // 2: both ports always valid, grants alternate from pointer 0
    do_reset();
    tick();
    set_req(0, 64'h3F800000, 64'h00000000, 2'd0, 3'd0, 4'd1);
    set_req(1, 64'h3FF0000000000000, 64'h0, 2'd1, 3'd1, 4'd2);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_ready", 64'(req_ready), (i % 2 == 0) ? 64'b01 : 64'b10);
      tick();
      chk("t2_src", 64'(rsrc), 64'(i % 2));
      chk("t2_tag", 64'(rtag), (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("t2_result", rres, (i % 2 == 0) ? 64'h3F800000 : 64'hBFF0000000000000);
      chk("t2_cnt", 64'(cnt), 64'(i + 1));
    end

    // 3: backpressure freezes outputs and blocks grants
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_ready_hold", 64'(req_ready), 64'b00);
      tick();
      chk("t3_valid", 64'(rvld), 64'd1);
      chk("t3_result", rres, 64'hBFF0000000000000);
      chk("t3_src", 64'(rsrc), 64'd1);
      chk("t3_cnt", 64'(cnt), 64'd4);
    end
    resp_ready = 1'b1;
    #1 chk("t3_ready_rel", 64'(req_ready), 64'b01);
    tick();
    chk("t3_src_rel", 64'(rsrc), 64'd0);
    chk("t3_cnt_rel", 64'(cnt), 64'd5);
    req_valid = 2'b00;
    tick();
    chk("pop_valid", 64'(rvld), 64'd0);
    chk("pop_keep", rres, 64'h3F800000);

    // 4: double-precision JX and JN on port 1
    set_req(1, 64'hC000000000000000, 64'h8000000000000000, 2'd1, 3'd2, 4'd3);
    req_valid = 2'b10;
    #1 chk("t4_ready", 64'(req_ready), 64'b10);
    tick();
    chk("t4_jx", rres, 64'h4000000000000000);
    chk("t4_src", 64'(rsrc), 64'd1);
    set_req(1, 64'h3FF0000000000000, 64'h0, 2'd1, 3'd1, 4'd4);
    tick();
    chk("t4_jn", rres, 64'hBFF0000000000000);
    chk("t4_cnt", 64'(cnt), 64'd7);

    // 5: illegal encodings, then enough ops to wrap the 4-bit twin
    req_valid = 2'b01;
    set_req(0, 64'h3F800000, 64'h80000000, 2'd0, 3'd3, 4'd6);
    tick();
    chk("t5_rm_ill", 64'(rill), 64'd1);
    chk("t5_rm_res", rres, 64'd0);
    set_req(0, 64'h3F800000, 64'h80000000, 2'd2, 3'd0, 4'd6);
    tick();
    chk("t5_fmt_ill", 64'(rill), 64'd1);
    chk("t5_fmt_res", rres, 64'd0);
    chk("t5_cnt", 64'(cnt), 64'd9);
    set_req(0, 64'h3F800000, 64'h80000000, 2'd0, 3'd0, 4'd6);
    for (int i = 0; i < 8; i++) tick();
    chk("t5_legal", 64'(rill), 64'd0);
    chk("t5_cnt16", 64'(cnt), 64'd17);
    chk("t5_wrap", 64'(cnt2), 64'd1);

    // 6: async reset while a result is held under backpressure
    set_req(1, 64'h3F800000, 64'h0, 2'd0, 3'd0, 4'd7);
    req_valid = 2'b10;
    tick();
    chk("t6_src1", 64'(rsrc), 64'd1);
    resp_ready = 1'b0;
    req_valid  = 2'b11;
    tick();
    chk("t6_held", 64'(rvld), 64'd1);
    do_reset();
    resp_ready = 1'b1;
    #1 chk("t6_ready_p0", 64'(req_ready), 64'b01);
    tick();
    chk("t6_src0", 64'(rsrc), 64'd0);
    chk("t6_cnt", 64'(cnt), 64'd1);
    req_valid = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
